viterbi_acs_ctrl: RTL and testbench
===================================

# viterbi_acs_ctrl

Sequencing controller for the 4-state ACSU of the K=3 Viterbi decoder. It holds the path-metric register bank and feeds it back to the ACSU. Each accepted branch-metric symbol advances one trellis step: the controller latches the new path metrics with MSB normalization and forwards the 4 decision bits to traceback under a valid/ready handshake. It frames each block of FRAME_LEN+TAIL_LEN steps and reports the final best state; it sits between the BMU and the traceback unit.

## Interface
- PM_WIDTH, 8: path-metric width; matches the ACSU.
- FRAME_LEN, 64: information steps per frame.
- TAIL_LEN, 2: flush steps per frame (K-1).
- PM_INIT, 64: initial metric of states 1..3 (state 0 starts at 0).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  frame start pulse; honoured only in IDLE.
- sym_valid_i  in  1  BMU metrics for this step are valid at the ACSU inputs.
- sym_ready_o  out  1  step accepted when sym_valid_i && sym_ready_o.
- acs_pm_s0_i..acs_pm_s3_i  in  PM_WIDTH each  new metrics from the ACSU.
- acs_dec_i  in  4  ACSU decision bits.
- pm_s0_o..pm_s3_o  out  PM_WIDTH each  registered metrics to the ACSU.
- dec_valid_o  out  1  decision word valid for traceback.
- dec_bits_o  out  4  decision word.
- dec_step_o  out  STEP_W  trellis step index of dec_bits_o; STEP_W = $clog2(FRAME_LEN+TAIL_LEN).
- dec_ready_i  in  1  traceback accepts the decision word.
- frame_done_o  out  1  one-cycle pulse at frame end.
- best_state_o  out  2  argmin of final metrics; held until the next frame_done_o.
- busy_o  out  1  high outside IDLE.

## Operation
- States:
  - IDLE: start_i → load PMs {0, PM_INIT, PM_INIT, PM_INIT}, clear the step counter, go to RUN.
  - RUN: accept steps. Go to DONE on the accept of step FRAME_LEN+TAIL_LEN-1.
  - DONE: wait until the decision output is empty or draining (!dec_valid_o || dec_ready_i). Then pulse frame_done_o, update best_state_o, go to IDLE.
- Handshakes:
  - sym_ready_o = (state==RUN) && (!dec_valid_o || dec_ready_i). The decision register never overflows.
  - On accept:
    - PM registers ← normalized ACSU outputs.
    - dec_bits_o ← acs_dec_i; dec_step_o ← step counter; dec_valid_o ← 1.
    - Step counter increments.
  - dec_valid_o clears when dec_ready_i && dec_valid_o with no new accept in the same cycle. Accept and drain together keep it at 1 with new data.
  - While dec_valid_o && !dec_ready_i, dec_bits_o and dec_step_o hold stable.
- Normalization: if all four ACSU outputs have bit PM_WIDTH-1 set, clear that bit in all four (subtract 2^(PM_WIDTH-1)); otherwise register them unchanged. Saturated values (all ones) are normalized like any other value.
- Best state: minimum of the final registered PMs; ties go to the lowest index.
- Ignored inputs: start_i outside IDLE; sym_valid_i outside RUN.
- Reset mid-frame: asynchronous return to IDLE with reset values. Any pending decision is discarded.

## Timing
- Reset values:
  - pm_s0_o = 0; pm_s1_o..pm_s3_o = PM_INIT.
  - dec_valid_o, dec_bits_o, dec_step_o, frame_done_o, best_state_o, busy_o, sym_ready_o all 0.
- start_i sampled in cycle C → busy_o=1 and sym_ready_o=1 in C+1 (given dec_valid_o=0).
- Accept at edge ending cycle N → new PMs and decision visible in N+1. Throughput is 1 step/cycle while dec_ready_i=1.
- Last accept at edge ending N:
  - DONE in N+1.
  - If dec_ready_i=1 in N+1: frame_done_o=1, busy_o=0 and new best_state_o in N+2.
  - Each stalled cycle delays this by one.
- A new start_i is accepted in the cycle of frame_done_o (state IDLE).

## Structure
- viterbi_pkg holds:
  - NUM_STATES=4.
  - ctrl_state_t enum {IDLE, RUN, DONE}.
  - STEP_W helper function.
  - Default PM_WIDTH.
- Sub-module pm_min4: 4-input argmin with lowest-index tie break, returning a 2-bit index. It is combinational and reused by traceback start-state selection.

## Test plan
- Reset with no stimulus → all outputs at reset values; pm_s1_o = 64. start_i pulse → busy_o=1 in the next cycle.
- Error-free all-zero codeword, 66 symbols, dec_ready_i=1 → 66 consecutive decision beats, dec_step_o 0..65, pm_s0_o stays 0, frame_done_o two cycles after the last accept, best_state_o=0.
- dec_ready_i low for 5 cycles mid-frame → sym_ready_o low throughout; dec_bits_o, dec_step_o and PMs stable; no step lost or duplicated afterwards.
- ACSU stub outputs 130/131/200/255 → registered 2/3/72/127. Stub outputs 127/200/200/200 → registered unchanged.
- rst_ni asserted at step 10 → immediate reset values. A following start_i runs a full frame with dec_step_o restarting at 0.
- start_i pulsed during RUN is ignored. Final PMs 5/3/3/9 → best_state_o=1.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared types and helpers for the K=3 Viterbi decoder blocks.
`default_nettype none

package viterbi_pkg;

   localparam int NUM_STATES   = 4;
   localparam int PM_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

   function automatic int step_w(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/viterbi_acs_ctrl_pm_min4.sv
// pm_min4: combinational 4-way argmin of path metrics, lowest index wins ties.
`default_nettype none

module pm_min4 #(
   parameter int W = 8
) (
   input  logic [W-1:0] pm0,
   input  logic [W-1:0] pm1,
   input  logic [W-1:0] pm2,
   input  logic [W-1:0] pm3,
   output logic [1:0]   idx
);

   logic         sel01;
   logic         sel23;
   logic [W-1:0] min01;
   logic [W-1:0] min23;

   // Strict less-than keeps the lower index on equal metrics.
   assign sel01 = (pm1 < pm0);
   assign sel23 = (pm3 < pm2);
   assign min01 = sel01 ? pm1 : pm0;
   assign min23 = sel23 ? pm3 : pm2;
   assign idx   = (min23 < min01) ? {1'b1, sel23} : {1'b0, sel01};

endmodule

`default_nettype wire

// File: rtl/viterbi_acs_ctrl.sv
// viterbi_acs_ctrl: path-metric bank, step sequencing and decision hand-off for the 4-state ACSU.
`default_nettype none

module viterbi_acs_ctrl
   import viterbi_pkg::*;
#(
   parameter  int PM_WIDTH  = PM_WIDTH_DEF,
   parameter  int FRAME_LEN = 64,
   parameter  int TAIL_LEN  = 2,
   parameter  int PM_INIT   = 64,
   localparam int STEP_W    = step_w(FRAME_LEN + TAIL_LEN)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic                sym_valid_i,
   output logic                sym_ready_o,
   input  logic [PM_WIDTH-1:0] acs_pm_s0_i,
   input  logic [PM_WIDTH-1:0] acs_pm_s1_i,
   input  logic [PM_WIDTH-1:0] acs_pm_s2_i,
   input  logic [PM_WIDTH-1:0] acs_pm_s3_i,
   input  logic [3:0]          acs_dec_i,
   output logic [PM_WIDTH-1:0] pm_s0_o,
   output logic [PM_WIDTH-1:0] pm_s1_o,
   output logic [PM_WIDTH-1:0] pm_s2_o,
   output logic [PM_WIDTH-1:0] pm_s3_o,
   output logic                dec_valid_o,
   output logic [3:0]          dec_bits_o,
   output logic [STEP_W-1:0]   dec_step_o,
   input  logic                dec_ready_i,
   output logic                frame_done_o,
   output logic [1:0]          best_state_o,
   output logic                busy_o
);

   localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(FRAME_LEN + TAIL_LEN - 1);
   localparam logic [PM_WIDTH-1:0] PM_INIT_V = PM_WIDTH'(PM_INIT);
   localparam logic [PM_WIDTH-1:0] MSB_CLR   = {1'b0, {(PM_WIDTH-1){1'b1}}};

   ctrl_state_t         state;
   logic [STEP_W-1:0]   step;
   logic                drain_ok;
   logic                accept;
   logic                norm_all;
   logic [PM_WIDTH-1:0] n0, n1, n2, n3;
   logic [1:0]          min_idx;

   assign drain_ok    = !dec_valid_o || dec_ready_i;
   assign sym_ready_o = (state == RUN) && drain_ok;
   assign accept      = sym_valid_i && sym_ready_o;
   assign busy_o      = (state != IDLE);

   // Metrics only ever grow, so once every MSB is set the common offset can be dropped.
   assign norm_all = acs_pm_s0_i[PM_WIDTH-1] & acs_pm_s1_i[PM_WIDTH-1] &
                     acs_pm_s2_i[PM_WIDTH-1] & acs_pm_s3_i[PM_WIDTH-1];
   assign n0 = norm_all ? (acs_pm_s0_i & MSB_CLR) : acs_pm_s0_i;
   assign n1 = norm_all ? (acs_pm_s1_i & MSB_CLR) : acs_pm_s1_i;
   assign n2 = norm_all ? (acs_pm_s2_i & MSB_CLR) : acs_pm_s2_i;
   assign n3 = norm_all ? (acs_pm_s3_i & MSB_CLR) : acs_pm_s3_i;

   pm_min4 #(.W(PM_WIDTH)) u_pm_min4 (
      .pm0 (pm_s0_o),
      .pm1 (pm_s1_o),
      .pm2 (pm_s2_o),
      .pm3 (pm_s3_o),
      .idx (min_idx)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         step         <= '0;
         pm_s0_o      <= '0;
         pm_s1_o      <= PM_INIT_V;
         pm_s2_o      <= PM_INIT_V;
         pm_s3_o      <= PM_INIT_V;
         dec_valid_o  <= 1'b0;
         dec_bits_o   <= '0;
         dec_step_o   <= '0;
         frame_done_o <= 1'b0;
         best_state_o <= '0;
      end else begin
         frame_done_o <= 1'b0;

         if (accept) begin
            pm_s0_o     <= n0;
            pm_s1_o     <= n1;
            pm_s2_o     <= n2;
            pm_s3_o     <= n3;
            dec_bits_o  <= acs_dec_i;
            dec_step_o  <= step;
            dec_valid_o <= 1'b1;
            step        <= step + 1'b1;
         end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  pm_s0_o <= '0;
                  pm_s1_o <= PM_INIT_V;
                  pm_s2_o <= PM_INIT_V;
                  pm_s3_o <= PM_INIT_V;
                  step    <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (accept && (step == LAST_STEP)) state <= DONE;
            end
            DONE: begin
               if (drain_ok) begin
                  frame_done_o <= 1'b1;
                  best_state_o <= min_idx;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_viterbi_acs_ctrl.sv
// tb_viterbi_acs_ctrl: directed + scoreboard bench for viterbi_acs_ctrl.
`default_nettype none

module tb_viterbi_acs_ctrl;

   localparam int W   = 8;
   localparam int TOT = 66;
   localparam int SW  = 7;

   typedef struct packed {
      logic [SW-1:0] step;
      logic [3:0]    bits;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          sym_valid = 1'b0;
   logic          dec_ready = 1'b0;
   logic [W-1:0]  a0 = '0, a1 = '0, a2 = '0, a3 = '0;
   logic [3:0]    adec = '0;
   logic          sym_ready, dec_valid, frame_done, busy;
   logic [W-1:0]  pm0, pm1, pm2, pm3;
   logic [3:0]    dec_bits;
   logic [SW-1:0] dec_step;
   logic [1:0]    best;

   viterbi_acs_ctrl dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .sym_valid_i  (sym_valid),
      .sym_ready_o  (sym_ready),
      .acs_pm_s0_i  (a0),
      .acs_pm_s1_i  (a1),
      .acs_pm_s2_i  (a2),
      .acs_pm_s3_i  (a3),
      .acs_dec_i    (adec),
      .pm_s0_o      (pm0),
      .pm_s1_o      (pm1),
      .pm_s2_o      (pm2),
      .pm_s3_o      (pm3),
      .dec_valid_o  (dec_valid),
      .dec_bits_o   (dec_bits),
      .dec_step_o   (dec_step),
      .dec_ready_i  (dec_ready),
      .frame_done_o (frame_done),
      .best_state_o (best),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   beat_t       sbq[$];
   logic [31:0] exp_pm = 32'h0040_4040;
   bit          m_run = 0, m_done = 0, m_fd = 0;
   logic [1:0]  m_best = 2'd0;
   int          m_step = 0;
   int          beats  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] norm4(input logic [31:0] v);
      if (v[31] && v[23] && v[15] && v[7]) return v & 32'h7f7f_7f7f;
      return v;
   endfunction

   function automatic logic [1:0] argmin(input logic [31:0] v);
      logic [1:0] bi = 2'd0;
      logic [7:0] bv = v[31:24];
      for (int k = 1; k < 4; k++) begin
         if (v[31-8*k -: 8] < bv) begin
            bv = v[31-8*k -: 8];
            bi = 2'(k);
         end
      end
      return bi;
   endfunction

   task automatic set_stub(input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] v2, input logic [7:0] v3);
      a0 = v0; a1 = v1; a2 = v2; a3 = v3;
   endtask

   task automatic reset_model();
      sbq.delete();
      m_run = 0; m_done = 0; m_fd = 0; m_best = 2'd0; m_step = 0;
      exp_pm = 32'h0040_4040;
   endtask

   // One clock: compare at the falling edge, then advance the model over the rising edge.
   task automatic cycle();
      bit    drain, acc, start_acc, done_go;
      beat_t b;
      @(negedge clk);
      chk("dec_valid", 32'(dec_valid), 32'(sbq.size() != 0));
      chk("sym_ready", 32'(sym_ready), 32'(m_run && (sbq.size() == 0 || dec_ready)));
      chk("busy", 32'(busy), 32'(m_run || m_done));
      chk("pm", {pm0, pm1, pm2, pm3}, exp_pm);
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("best_state", 32'(best), 32'(m_best));
      if (sbq.size() != 0) begin
         chk("dec_step", 32'(dec_step), 32'(sbq[0].step));
         chk("dec_bits", 32'(dec_bits), 32'(sbq[0].bits));
      end
      drain     = (sbq.size() != 0) && dec_ready;
      acc       = m_run && (sbq.size() == 0 || dec_ready) && sym_valid;
      start_acc = !m_run && !m_done && start;
      done_go   = m_done && (sbq.size() == 0 || dec_ready);
      b.step    = SW'(m_step);
      b.bits    = adec;
      @(posedge clk);
      #1;
      if (drain) begin
         void'(sbq.pop_front());
         beats++;
      end
      if (acc) begin
         sbq.push_back(b);
         exp_pm = norm4({a0, a1, a2, a3});
         m_step++;
         if (m_step == TOT) begin
            m_run  = 0;
            m_done = 1;
         end
      end
      if (start_acc) begin
         m_run  = 1;
         m_step = 0;
         exp_pm = 32'h0040_4040;
      end
      m_fd = done_go;
      if (done_go) begin
         m_done = 0;
         m_best = argmin(exp_pm);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      // Reset state
      cycle();
      chk("rst_pm1", 32'(pm1), 32'd64);
      chk("rst_dec_bits", 32'(dec_bits), 32'd0);
      chk("rst_dec_step", 32'(dec_step), 32'd0);
      rst_n = 1'b1;
      cycle();

      // Frame 1: error-free all-zero path, one stall of five cycles mid-frame
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_ready", 32'(sym_ready), 32'd1);
      set_stub(8'd0, 8'd10, 8'd20, 8'd30);
      sym_valid = 1'b1;
      dec_ready = 1'b1;
      beats = 0;
      for (int i = 0; i < TOT; i++) begin
         adec = 4'((i * 7) & 15);
         if (i == 30) begin
            dec_ready = 1'b0;
            a1 = 8'd99;
            repeat (5) cycle();
            chk("stall_pm1", 32'(pm1), 32'd10);
            a1 = 8'd10;
            dec_ready = 1'b1;
         end
         cycle();
      end
      sym_valid = 1'b0;
      repeat (3) cycle();
      chk("f1_beats", 32'(beats), 32'd66);
      chk("f1_pm0", 32'(pm0), 32'd0);

      // Frame 2: normalization cases, ignored start, tie on final metrics
      start = 1'b1;
      cycle();
      start = 1'b0;
      sym_valid = 1'b1;
      beats = 0;
      for (int i = 0; i < TOT; i++) begin
         adec = 4'($urandom_range(0, 15));
         if (i == 5)            set_stub(8'd130, 8'd131, 8'd200, 8'd255);
         else if (i == 6)       set_stub(8'd127, 8'd200, 8'd200, 8'd200);
         else if (i == TOT - 1) set_stub(8'd5, 8'd3, 8'd3, 8'd9);
         else                   set_stub(8'd1, 8'd2, 8'd3, 8'd4);
         start = (i == 20);
         cycle();
         if (i == 5) chk("norm_all_msb", {pm0, pm1, pm2, pm3}, {8'd2, 8'd3, 8'd72, 8'd127});
         if (i == 6) chk("norm_none", {pm0, pm1, pm2, pm3}, {8'd127, 8'd200, 8'd200, 8'd200});
      end
      start = 1'b0;
      sym_valid = 1'b0;
      cycle();
      cycle();
      chk("f2_best", 32'(best), 32'd1);
      chk("f2_beats", 32'(beats), 32'd66);
      cycle();

      // Frame 3: asynchronous reset after ten steps
      start = 1'b1;
      cycle();
      start = 1'b0;
      sym_valid = 1'b1;
      set_stub(8'd40, 8'd7, 8'd50, 8'd60);
      for (int i = 0; i < 10; i++) begin
         adec = 4'(i);
         cycle();
      end
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_state", {7'(dec_step), dec_valid, dec_bits, frame_done, busy, sym_ready, best},
          32'd0);
      chk("arst_pm", {pm0, pm1, pm2, pm3}, 32'h0040_4040);
      reset_model();
      sym_valid = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle();

      // Frame 4: full frame after reset under random back-pressure
      start = 1'b1;
      cycle();
      start = 1'b0;
      sym_valid = 1'b1;
      beats = 0;
      g = 0;
      while (m_run && g < 600) begin
         adec = 4'($urandom_range(0, 15));
         dec_ready = ($urandom_range(0, 3) != 0);
         if (m_step == TOT - 1) set_stub(8'd9, 8'd9, 8'd2, 8'd4);
         else                   set_stub(8'd0, 8'd10, 8'd20, 8'd30);
         cycle();
         g++;
      end
      chk("f4_in_budget", 32'(m_run), 32'd0);
      sym_valid = 1'b0;
      dec_ready = 1'b1;
      repeat (3) cycle();
      chk("f4_beats", 32'(beats), 32'd66);
      chk("f4_best", 32'(best), 32'd2);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
